// File: rtl/rv32i_bp_pkg.sv
// Shared definitions for the rv32i branch predictor: 2-bit counter encodings and saturating update.
// The gshare option (RV32I_BP_GSHARE_EN) is handled in the top module.
package rv32i_bp_pkg;

  typedef enum logic [1:0] {
    CTR_SNT = 2'b00,
    CTR_WNT = 2'b01,
    CTR_WT  = 2'b10,
    CTR_ST  = 2'b11
  } ctr_e;

  localparam ctr_e CTR_RESET = CTR_WNT;

  function automatic ctr_e ctr_next(input ctr_e cur, input logic taken);
    logic [1:0] cur_l;
    ctr_e       nxt;
    cur_l = cur;
    nxt   = cur;
    if (taken && (cur != CTR_ST)) begin
      nxt = ctr_e'(cur_l + 2'd1);
    end else if (!taken && (cur != CTR_SNT)) begin
      nxt = ctr_e'(cur_l - 2'd1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/rv32i_bp_counter_table.sv
// ENTRIES x 2-bit saturating counter array: one combinational read port and one
// read-modify-write update port; asynchronous active-high reset to weakly-not-taken.
module rv32i_bp_counter_table
  import rv32i_bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [1:0]       rd_ctr_o,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic             wr_taken_i
);

  ctr_e ctr_q [ENTRIES];

  assign rd_ctr_o = ctr_q[rd_idx_i];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        ctr_q[i] <= CTR_RESET;
      end
    end else if (wr_en_i) begin
      ctr_q[wr_idx_i] <= ctr_next(ctr_q[wr_idx_i], wr_taken_i);
    end
  end

endmodule

// File: rtl/rv32i_branch_predictor.sv
// Bimodal (or gshare when RV32I_BP_GSHARE_EN is defined) predictor with a tagged BTB.
// Lookup is combinational from registered state; updates land on the rising edge, no bypass.
module rv32i_branch_predictor
  import rv32i_bp_pkg::*;
#(
  parameter  int PC_W    = 8,
  parameter  int ENTRIES = 16,
  parameter  int CNT_W   = 16,
  parameter  int GHR_W   = 4,
  localparam int IDX_W   = $clog2(ENTRIES),
  localparam int TAG_W   = PC_W - 2 - IDX_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PC_W-1:0]  f_pc,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  output logic [IDX_W-1:0] pred_idx,
  input  logic             upd_valid,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken,
  input  logic [PC_W-1:0]  upd_target,
  input  logic             upd_mispredict,
  output logic [CNT_W-1:0] perf_mispredict
);

  logic [IDX_W-1:0] f_bidx, u_bidx;
  logic [TAG_W-1:0] f_tag, u_tag;
  logic [GHR_W-1:0] hist;
  logic [1:0]       ctr_rd;
  logic             hit;

  logic [ENTRIES-1:0] btb_valid_q;
  logic [TAG_W-1:0]   btb_tag_q    [ENTRIES];
  logic [PC_W-1:0]    btb_target_q [ENTRIES];
  logic [CNT_W-1:0]   perf_q, perf_d;

  assign f_bidx = f_pc[IDX_W+1:2];
  assign f_tag  = f_pc[PC_W-1:IDX_W+2];
  assign u_bidx = upd_pc[IDX_W+1:2];
  assign u_tag  = upd_pc[PC_W-1:IDX_W+2];

`ifdef RV32I_BP_GSHARE_EN
  logic [GHR_W-1:0] ghr_q, ghr_d;

  // History is non-speculative: it only advances when a branch resolves.
  assign ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ghr_q <= '0;
    end else if (upd_valid) begin
      ghr_q <= ghr_d;
    end
  end

  assign hist = ghr_q;
`else
  assign hist = '0;
`endif

  assign pred_idx = f_bidx ^ IDX_W'(hist);

  rv32i_bp_counter_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_ctr_table (
    .clk        (clk),
    .rst        (rst),
    .rd_idx_i   (pred_idx),
    .rd_ctr_o   (ctr_rd),
    .wr_en_i    (upd_valid),
    .wr_idx_i   (upd_idx),
    .wr_taken_i (upd_taken)
  );

  assign hit         = btb_valid_q[f_bidx] && (btb_tag_q[f_bidx] == f_tag);
  assign pred_taken  = hit && ctr_rd[1];
  assign pred_target = pred_taken ? btb_target_q[f_bidx] : f_pc + PC_W'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btb_valid_q <= '0;
    end else if (upd_valid && upd_taken) begin
      btb_valid_q[u_bidx] <= 1'b1;
    end
  end

  // Tag/target need no reset: they are only observed through a set valid bit.
  always_ff @(posedge clk) begin
    if (!rst && upd_valid && upd_taken) begin
      btb_tag_q[u_bidx]    <= u_tag;
      btb_target_q[u_bidx] <= upd_target;
    end
  end

  always_comb begin
    perf_d = perf_q;
    if (upd_valid && upd_mispredict && (perf_q != '1)) begin
      perf_d = perf_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_mispredict = perf_q;

  logic unused_bits;
  assign unused_bits = ^{f_pc[1:0], upd_pc[1:0], ctr_rd[0]};

endmodule

// File: tb/tb_rv32i_branch_predictor.sv
// Directed self-checking bench for rv32i_branch_predictor (PC_W=8, ENTRIES=16, CNT_W=2).
// The gshare index check is compiled in when RV32I_BP_GSHARE_EN is defined.
module tb_rv32i_branch_predictor;

  localparam int PC_W  = 8;
  localparam int IDX_W = 4;
  localparam int CNT_W = 2;

  logic             clk;
  logic             rst;
  logic [PC_W-1:0]  f_pc;
  logic             pred_taken;
  logic [PC_W-1:0]  pred_target;
  logic [IDX_W-1:0] pred_idx;
  logic             upd_valid;
  logic [PC_W-1:0]  upd_pc;
  logic [IDX_W-1:0] upd_idx;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic             upd_mispredict;
  logic [CNT_W-1:0] perf_mispredict;

  int checks   = 0;
  int failures = 0;

  rv32i_branch_predictor #(
    .PC_W    (PC_W),
    .ENTRIES (16),
    .CNT_W   (CNT_W),
    .GHR_W   (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .f_pc            (f_pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .pred_idx        (pred_idx),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_idx         (upd_idx),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_mispredict  (upd_mispredict),
    .perf_mispredict (perf_mispredict)
  );

  // clock/reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    upd_valid = 1'b0;
    upd_mispredict = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic do_update(input logic [PC_W-1:0] pc, input logic [IDX_W-1:0] idx,
                           input logic taken, input logic [PC_W-1:0] tgt, input logic mis);
    upd_pc         = pc;
    upd_idx        = idx;
    upd_taken      = taken;
    upd_target     = tgt;
    upd_mispredict = mis;
    upd_valid      = 1'b1;
    @(posedge clk); #1;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  task automatic lookup(input logic [PC_W-1:0] pc);
    f_pc = pc;
    #1;
  endtask

  initial begin
    f_pc = 8'h10; upd_pc = '0; upd_idx = '0; upd_taken = 1'b0; upd_target = '0;
    apply_reset();

    // post-reset defaults
    lookup(8'h10);
    check_val("rst_taken",  pred_taken,  0);
    check_val("rst_target", pred_target, 8'h14);
    check_val("rst_idx",    pred_idx,    4);
    check_val("rst_perf",   perf_mispredict, 0);
    lookup(8'hFC);
    check_val("wrap_target", pred_target, 8'h00);
    check_val("wrap_idx",    pred_idx,    15);

    // taken training
    do_update(8'h10, 4'd4, 1'b1, 8'h40, 1'b0);
    lookup(8'h10);
    check_val("train_taken",  pred_taken,  1);
    check_val("train_target", pred_target, 8'h40);

    // aliasing: same index, different tag
    lookup(8'h50);
    check_val("alias_miss_taken",  pred_taken,  0);
    check_val("alias_miss_target", pred_target, 8'h54);
    do_update(8'h50, 4'd4, 1'b1, 8'h80, 1'b0);
    lookup(8'h10);
    check_val("evict_taken",  pred_taken,  0);
    check_val("evict_target", pred_target, 8'h14);
    lookup(8'h50);
    check_val("new_taken",  pred_taken,  1);
    check_val("new_target", pred_target, 8'h80);

    // counter saturation from WNT at index 4
    apply_reset();
    for (int i = 0; i < 4; i++) do_update(8'h10, 4'd4, 1'b1, 8'h40, 1'b0);
    do_update(8'h10, 4'd4, 1'b0, 8'h20, 1'b0);
    lookup(8'h10);
    check_val("wt_taken",  pred_taken,  1);
    check_val("wt_target", pred_target, 8'h40);
    do_update(8'h10, 4'd4, 1'b0, 8'h20, 1'b0);
    lookup(8'h10);
    check_val("wnt_taken", pred_taken, 0);
    do_update(8'h10, 4'd4, 1'b0, 8'h20, 1'b0);
    do_update(8'h10, 4'd4, 1'b0, 8'h20, 1'b0);
    lookup(8'h10);
    check_val("snt_taken",  pred_taken,  0);
    check_val("snt_target", pred_target, 8'h14);
    do_update(8'h10, 4'd4, 1'b1, 8'h40, 1'b0);
    lookup(8'h10);
    check_val("snt_up_wnt", pred_taken, 0);
    do_update(8'h10, 4'd4, 1'b1, 8'h40, 1'b0);
    lookup(8'h10);
    check_val("wnt_up_wt", pred_taken, 1);

    // same-cycle lookup and update: counter is WT, a not-taken drops it to WNT
    f_pc = 8'h10;
    upd_pc = 8'h10; upd_idx = 4'd4; upd_taken = 1'b0; upd_target = 8'h20;
    upd_mispredict = 1'b0; upd_valid = 1'b1;
    #1;
    check_val("same_cycle_old", pred_taken, 1);
    @(posedge clk); #1;
    upd_valid = 1'b0;
    check_val("same_cycle_new", pred_taken, 0);

    // perf counter saturation with CNT_W=2, and upd_mispredict ignored without upd_valid
    apply_reset();
    do_update(8'h20, 4'd8, 1'b0, 8'h00, 1'b1);
    check_val("perf_one", perf_mispredict, 1);
    upd_mispredict = 1'b1; upd_valid = 1'b0;
    @(posedge clk); #1;
    upd_mispredict = 1'b0;
    check_val("perf_no_valid", perf_mispredict, 1);
    do_update(8'h20, 4'd8, 1'b0, 8'h00, 1'b1);
    check_val("perf_two", perf_mispredict, 2);
    for (int i = 0; i < 3; i++) do_update(8'h20, 4'd8, 1'b0, 8'h00, 1'b1);
    check_val("perf_sat", perf_mispredict, 3);

    // async reset between edges
    do_update(8'h10, 4'd4, 1'b1, 8'h40, 1'b0);
    lookup(8'h10);
    check_val("pre_async_taken", pred_taken, 1);
    rst = 1'b1;
    #1;
    check_val("async_taken",  pred_taken,      0);
    check_val("async_target", pred_target,     8'h14);
    check_val("async_perf",   perf_mispredict, 0);
    // an update presented while reset is held must be discarded
    upd_pc = 8'h10; upd_idx = 4'd4; upd_taken = 1'b1; upd_target = 8'h40;
    upd_mispredict = 1'b1; upd_valid = 1'b1;
    @(posedge clk); #1;
    upd_valid = 1'b0; upd_mispredict = 1'b0;
    rst = 1'b0;
    #1;
    check_val("rst_discard_taken", pred_taken,      0);
    check_val("rst_discard_perf",  perf_mispredict, 0);

    // history-indexed counter selection
    apply_reset();
    do_update(8'h10, 4'd4, 1'b1, 8'h40, 1'b0);
    do_update(8'h10, 4'd4, 1'b1, 8'h40, 1'b0);
    lookup(8'h10);
`ifdef RV32I_BP_GSHARE_EN
    check_val("gshare_idx", pred_idx, 7);
`else
    check_val("bimodal_idx", pred_idx, 4);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
